// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-stage forwarding, operand selection and load-use
// hazard detection. Drives the ALU opcode/operand inputs directly.

`ifndef ALU_ADDU
`define ALU_ADDU 4'b0000
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'b0001
`endif

module ex_operand_stage #(
  parameter int unsigned BUBBLE_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [4:0]              id_rs_addr,
  input  logic [4:0]              id_rt_addr,
  input  logic                    id_uses_rt,
  input  logic [31:0]             id_rs_data,
  input  logic [31:0]             id_rt_data,
  input  logic [31:0]             id_imm,
  input  logic [4:0]              id_shamt,
  input  logic [3:0]              id_alu_opcode,
  input  logic                    id_alu_src_imm,
  input  logic                    id_shift_shamt,
  input  logic                    id_reg_write,
  input  logic [4:0]              id_write_addr,
  input  logic                    id_mem_read,
  input  logic                    flush,
  input  logic                    mem_reg_write,
  input  logic [4:0]              mem_write_addr,
  input  logic [31:0]             mem_result,
  input  logic                    wb_reg_write,
  input  logic [4:0]              wb_write_addr,
  input  logic [31:0]             wb_result,
  output logic                    stall_id,
  output logic                    ex_valid,
  output logic [3:0]              alu_opcode,
  output logic [31:0]             alu_op_x,
  output logic [31:0]             alu_op_y,
  output logic [31:0]             ex_store_data,
  output logic                    ex_reg_write,
  output logic [4:0]              ex_write_addr,
  output logic                    ex_mem_read,
  output logic [BUBBLE_CNT_W-1:0] bubble_count
);

  logic [4:0]  ex_rs_addr;
  logic [4:0]  ex_rt_addr;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_shamt;
  logic        ex_alu_src_imm;
  logic        ex_shift_shamt;
  logic        hazard;
  logic        load_bubble;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  // A load in EX whose destination is read by the instruction in decode.
  assign hazard = id_valid & ex_valid & ex_mem_read & (ex_write_addr != 5'd0) &
                  ((ex_write_addr == id_rs_addr) |
                   (id_uses_rt & (ex_write_addr == id_rt_addr)));

  assign stall_id    = hazard & ~flush;
  assign load_bubble = flush | hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid       <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_write_addr  <= 5'd0;
      alu_opcode     <= `ALU_ADDU;
      ex_rs_addr     <= 5'd0;
      ex_rt_addr     <= 5'd0;
      ex_rs_data     <= 32'd0;
      ex_rt_data     <= 32'd0;
      ex_imm         <= 32'd0;
      ex_shamt       <= 5'd0;
      ex_alu_src_imm <= 1'b0;
      ex_shift_shamt <= 1'b0;
    end else if (load_bubble) begin
      ex_valid       <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_write_addr  <= 5'd0;
      alu_opcode     <= `ALU_ADDU;
      ex_rs_addr     <= 5'd0;
      ex_rt_addr     <= 5'd0;
      ex_rs_data     <= 32'd0;
      ex_rt_data     <= 32'd0;
      ex_imm         <= 32'd0;
      ex_shamt       <= 5'd0;
      ex_alu_src_imm <= 1'b0;
      ex_shift_shamt <= 1'b0;
    end else begin
      ex_valid       <= id_valid;
      ex_reg_write   <= id_valid & id_reg_write;
      ex_mem_read    <= id_valid & id_mem_read;
      ex_write_addr  <= id_write_addr;
      alu_opcode     <= id_alu_opcode;
      ex_rs_addr     <= id_rs_addr;
      ex_rt_addr     <= id_rt_addr;
      ex_rs_data     <= id_rs_data;
      ex_rt_data     <= id_rt_data;
      ex_imm         <= id_imm;
      ex_shamt       <= id_shamt;
      ex_alu_src_imm <= id_alu_src_imm;
      ex_shift_shamt <= id_shift_shamt;
    end
  end

  // Counts hazard bubbles only; flush bubbles are not stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count <= '0;
    end else if (hazard && !flush && (bubble_count != {BUBBLE_CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end

  // MEM wins over WB; r0 is never forwarded.
  always_comb begin
    fwd_rs = ex_rs_data;
    if (mem_reg_write && (mem_write_addr != 5'd0) && (mem_write_addr == ex_rs_addr)) begin
      fwd_rs = mem_result;
    end else if (wb_reg_write && (wb_write_addr != 5'd0) && (wb_write_addr == ex_rs_addr)) begin
      fwd_rs = wb_result;
    end
  end

  always_comb begin
    fwd_rt = ex_rt_data;
    if (mem_reg_write && (mem_write_addr != 5'd0) && (mem_write_addr == ex_rt_addr)) begin
      fwd_rt = mem_result;
    end else if (wb_reg_write && (wb_write_addr != 5'd0) && (wb_write_addr == ex_rt_addr)) begin
      fwd_rt = wb_result;
    end
  end

  assign alu_op_x      = ex_shift_shamt ? {27'd0, ex_shamt} : fwd_rs;
  assign alu_op_y      = ex_alu_src_imm ? ex_imm : fwd_rt;
  assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: capture, forwarding, operand select, load-use
// stalls, flush interaction, counter saturation (narrow instance) and async reset.

`ifndef ALU_ADDU
`define ALU_ADDU 4'b0000
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'b0001
`endif

module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic        id_uses_rt;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_shamt;
  logic [3:0]  id_alu_opcode;
  logic        id_alu_src_imm;
  logic        id_shift_shamt;
  logic        id_reg_write;
  logic [4:0]  id_write_addr;
  logic        id_mem_read;
  logic        flush;
  logic        mem_reg_write;
  logic [4:0]  mem_write_addr;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_write_addr;
  logic [31:0] wb_result;

  logic        stall_id, ex_valid, ex_reg_write, ex_mem_read;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_op_x, alu_op_y, ex_store_data;
  logic [4:0]  ex_write_addr;
  logic [15:0] bubble_count;

  logic        s_stall_id, s_ex_valid, s_ex_reg_write, s_ex_mem_read;
  logic [3:0]  s_alu_opcode;
  logic [31:0] s_alu_op_x, s_alu_op_y, s_ex_store_data;
  logic [4:0]  s_ex_write_addr;
  logic [1:0]  s_bubble_count;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.BUBBLE_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
    .id_alu_opcode(id_alu_opcode), .id_alu_src_imm(id_alu_src_imm),
    .id_shift_shamt(id_shift_shamt), .id_reg_write(id_reg_write),
    .id_write_addr(id_write_addr), .id_mem_read(id_mem_read), .flush(flush),
    .mem_reg_write(mem_reg_write), .mem_write_addr(mem_write_addr),
    .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_write_addr(wb_write_addr),
    .wb_result(wb_result), .stall_id(stall_id), .ex_valid(ex_valid),
    .alu_opcode(alu_opcode), .alu_op_x(alu_op_x), .alu_op_y(alu_op_y),
    .ex_store_data(ex_store_data), .ex_reg_write(ex_reg_write),
    .ex_write_addr(ex_write_addr), .ex_mem_read(ex_mem_read), .bubble_count(bubble_count)
  );

  // Narrow counter instance so saturation is reachable quickly.
  ex_operand_stage #(.BUBBLE_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
    .id_alu_opcode(id_alu_opcode), .id_alu_src_imm(id_alu_src_imm),
    .id_shift_shamt(id_shift_shamt), .id_reg_write(id_reg_write),
    .id_write_addr(id_write_addr), .id_mem_read(id_mem_read), .flush(flush),
    .mem_reg_write(mem_reg_write), .mem_write_addr(mem_write_addr),
    .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_write_addr(wb_write_addr),
    .wb_result(wb_result), .stall_id(s_stall_id), .ex_valid(s_ex_valid),
    .alu_opcode(s_alu_opcode), .alu_op_x(s_alu_op_x), .alu_op_y(s_alu_op_y),
    .ex_store_data(s_ex_store_data), .ex_reg_write(s_ex_reg_write),
    .ex_write_addr(s_ex_write_addr), .ex_mem_read(s_ex_mem_read),
    .bubble_count(s_bubble_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_uses_rt = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
    id_alu_opcode = `ALU_ADDU; id_alu_src_imm = 0; id_shift_shamt = 0;
    id_reg_write = 0; id_write_addr = 0; id_mem_read = 0; flush = 0;
    mem_reg_write = 0; mem_write_addr = 0; mem_result = 0;
    wb_reg_write = 0; wb_write_addr = 0; wb_result = 0;
  endtask

  // lw r4, 8(r1)
  task automatic drive_load_r4();
    idle_inputs();
    id_valid = 1; id_rs_addr = 5'd1; id_rs_data = 32'h100; id_alu_src_imm = 1;
    id_imm = 32'd8; id_reg_write = 1; id_write_addr = 5'd4; id_mem_read = 1;
  endtask

  // add r7, r4, r6
  task automatic drive_add_r4();
    idle_inputs();
    id_valid = 1; id_rs_addr = 5'd4; id_rt_addr = 5'd6; id_uses_rt = 1;
    id_rs_data = 32'h0; id_rt_data = 32'd3; id_alu_opcode = `ALU_ADD;
    id_reg_write = 1; id_write_addr = 5'd7;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #2;
    chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_opcode", {28'd0, alu_opcode}, {28'd0, `ALU_ADDU});
    chk("reset_bubbles", {16'd0, bubble_count}, 32'd0);
    chk("reset_stall", {31'd0, stall_id}, 32'd0);
    tick();
    rst = 0;

    // Plain capture: add r3, r1, r2 with r1=5, r2=7
    id_valid = 1; id_rs_addr = 5'd1; id_rt_addr = 5'd2; id_uses_rt = 1;
    id_rs_data = 32'd5; id_rt_data = 32'd7; id_alu_opcode = `ALU_ADD;
    id_reg_write = 1; id_write_addr = 5'd3;
    tick();
    chk("cap_valid", {31'd0, ex_valid}, 32'd1);
    chk("cap_op_x", alu_op_x, 32'd5);
    chk("cap_op_y", alu_op_y, 32'd7);
    chk("cap_opcode", {28'd0, alu_opcode}, {28'd0, `ALU_ADD});
    chk("cap_reg_write", {31'd0, ex_reg_write}, 32'd1);
    chk("cap_write_addr", {27'd0, ex_write_addr}, 32'd3);
    chk("cap_store", ex_store_data, 32'd7);

    // id_valid=0 captures a non-writing entry
    id_valid = 0; id_mem_read = 1;
    tick();
    chk("inv_valid", {31'd0, ex_valid}, 32'd0);
    chk("inv_reg_write", {31'd0, ex_reg_write}, 32'd0);
    chk("inv_mem_read", {31'd0, ex_mem_read}, 32'd0);

    // Forwarding: rs=r3, rt=r5
    idle_inputs();
    id_valid = 1; id_rs_addr = 5'd3; id_rt_addr = 5'd5; id_uses_rt = 1;
    id_rs_data = 32'h99; id_rt_data = 32'h77;
    tick();
    idle_inputs();
    mem_reg_write = 1; mem_write_addr = 5'd3; mem_result = 32'h11;
    wb_reg_write = 1; wb_write_addr = 5'd3; wb_result = 32'h22;
    #1;
    chk("fwd_mem_prio", alu_op_x, 32'h11);
    chk("fwd_rt_none", alu_op_y, 32'h77);
    mem_reg_write = 0;
    #1;
    chk("fwd_wb", alu_op_x, 32'h22);
    wb_write_addr = 5'd5;
    #1;
    chk("fwd_rs_rf", alu_op_x, 32'h99);
    chk("fwd_rt_wb", alu_op_y, 32'h22);
    chk("fwd_store_wb", ex_store_data, 32'h22);
    mem_reg_write = 1; mem_write_addr = 5'd5; mem_result = 32'h33; id_alu_src_imm = 1;
    #1;
    chk("fwd_store_mem", ex_store_data, 32'h33);

    // shamt / immediate select, store data still forwarded
    idle_inputs();
    id_valid = 1; id_rt_addr = 5'd5; id_rt_data = 32'h44; id_shift_shamt = 1;
    id_shamt = 5'd17; id_alu_src_imm = 1; id_imm = 32'hFFFF_FFF0; id_rs_data = 32'h55;
    tick();
    mem_reg_write = 1; mem_write_addr = 5'd5; mem_result = 32'h66;
    #1;
    chk("sel_shamt", alu_op_x, 32'd17);
    chk("sel_imm", alu_op_y, 32'hFFFF_FFF0);
    chk("sel_store_fwd", ex_store_data, 32'h66);

    // r0 guard
    idle_inputs();
    id_valid = 1; id_rs_addr = 5'd0; id_rt_addr = 5'd0;
    tick();
    mem_reg_write = 1; mem_write_addr = 5'd0; mem_result = 32'hDEAD;
    wb_reg_write = 1; wb_write_addr = 5'd0; wb_result = 32'hBEEF;
    #1;
    chk("r0_guard_x", alu_op_x, 32'd0);
    chk("r0_guard_y", alu_op_y, 32'd0);

    // Load-use: lw r4 then add using r4
    drive_load_r4();
    tick();
    chk("lu_load_mem_read", {31'd0, ex_mem_read}, 32'd1);
    drive_add_r4();
    #1;
    chk("lu_stall", {31'd0, stall_id}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_regw", {31'd0, ex_reg_write}, 32'd0);
    chk("lu_bubble_cnt", {16'd0, bubble_count}, 32'd1);
    chk("lu_stall_released", {31'd0, stall_id}, 32'd0);
    wb_reg_write = 1; wb_write_addr = 5'd4; wb_result = 32'hCAFE;
    tick();
    chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_add_fwd", alu_op_x, 32'hCAFE);
    chk("lu_add_y", alu_op_y, 32'd3);
    chk("lu_cnt_hold", {16'd0, bubble_count}, 32'd1);

    // Flush together with hazard
    drive_load_r4();
    tick();
    drive_add_r4();
    flush = 1;
    #1;
    chk("fl_stall", {31'd0, stall_id}, 32'd0);
    tick();
    chk("fl_bubble", {31'd0, ex_valid}, 32'd0);
    chk("fl_cnt", {16'd0, bubble_count}, 32'd1);

    // rt match is ignored when the instruction does not read rt
    drive_load_r4();
    tick();
    drive_add_r4();
    id_rs_addr = 5'd9; id_rt_addr = 5'd4;
    #1;
    chk("rt_used_stall", {31'd0, stall_id}, 32'd1);
    id_uses_rt = 0;
    #1;
    chk("rt_unused_stall", {31'd0, stall_id}, 32'd0);
    tick();
    chk("rt_unused_valid", {31'd0, ex_valid}, 32'd1);
    chk("rt_unused_cnt", {16'd0, bubble_count}, 32'd1);

    // Four more hazard bubbles: wide counter 5, 2-bit counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      drive_load_r4();
      tick();
      drive_add_r4();
      tick();
    end
    chk("sat_wide", {16'd0, bubble_count}, 32'd5);
    chk("sat_narrow", {30'd0, s_bubble_count}, 32'd3);

    // Async reset mid-stall, between edges
    drive_load_r4();
    tick();
    drive_add_r4();
    #1;
    chk("pre_rst_stall", {31'd0, stall_id}, 32'd1);
    rst = 1;
    #1;
    chk("arst_valid", {31'd0, ex_valid}, 32'd0);
    chk("arst_opcode", {28'd0, alu_opcode}, {28'd0, `ALU_ADDU});
    chk("arst_cnt", {16'd0, bubble_count}, 32'd0);
    chk("arst_stall", {31'd0, stall_id}, 32'd0);
    chk("arst_mem_read", {31'd0, ex_mem_read}, 32'd0);
    tick();
    chk("arst_hold_valid", {31'd0, ex_valid}, 32'd0);
    chk("arst_hold_cnt", {16'd0, bubble_count}, 32'd0);
    rst = 0;
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
ID/EX pipeline register plus EX-stage operand selection that directly feeds the ALU's alu_opcode/alu_op_x/alu_op_y inputs. Captures decoded instructions, forwards results from MEM and WB, selects shamt/immediate operands, and detects load-use hazards. On a hazard it stalls decode and inserts a bubble. A saturating bubble counter supports performance debug.

Parameters:
BUBBLE_CNT_W, 16, width of the saturating bubble counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  decode holds a valid instruction
id_rs_addr  in  5  source register rs
id_rt_addr  in  5  source register rt
id_uses_rt  in  1  instruction reads rt (R-type/store/branch)
id_rs_data  in  32  register-file rs value
id_rt_data  in  32  register-file rt value
id_imm  in  32  already-extended immediate
id_shamt  in  5  shift amount
id_alu_opcode  in  4  ALU opcode (mips_defines encoding)
id_alu_src_imm  in  1  op_y = immediate
id_shift_shamt  in  1  op_x = zero-extended shamt
id_reg_write  in  1  writes register file
id_write_addr  in  5  destination register
id_mem_read  in  1  load
flush  in  1  kill the instruction entering EX
mem_reg_write  in  1  MEM-stage instruction writes a register
mem_write_addr  in  5  MEM destination
mem_result  in  32  MEM-stage ALU result
wb_reg_write  in  1  WB-stage instruction writes a register
wb_write_addr  in  5  WB destination
wb_result  in  32  WB write-back data
stall_id  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a valid instruction
alu_opcode  out  4  to ALU
alu_op_x  out  32  to ALU
alu_op_y  out  32  to ALU
ex_store_data  out  32  forwarded rt for stores
ex_reg_write  out  1  registered, gated by valid
ex_write_addr  out  5  registered destination
ex_mem_read  out  1  registered, gated by valid
bubble_count  out  BUBBLE_CNT_W  bubbles inserted since reset

Behaviour:
- Reset (async, rst=1): all EX registers clear to 0. ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_write_addr=0, alu_opcode=`ALU_ADDU, bubble_count=0. Outputs stay stable while rst is high. A reset mid-stall drops the stall; stall_id=0 next cycle.
- Load-use hazard (combinational): hazard = id_valid & ex_valid & ex_mem_read & ex_write_addr!=0 & (ex_write_addr==id_rs_addr | (id_uses_rt & ex_write_addr==id_rt_addr)).
- stall_id = hazard & ~flush.
- Clock edge, priority order:
  - flush: load a bubble.
  - else hazard: load a bubble.
  - else capture all id_* fields, with ex_valid=id_valid.
- Bubble: valid=0, reg_write=0, mem_read=0; other fields are don't-care but are held to zero.
- id_valid=0 also captures as a non-writing entry: reg_write and mem_read are gated by id_valid.
- bubble_count increments by 1 per bubble caused by hazard, not by flush. It saturates at all-ones (no wrap).
- Forwarding (combinational, from registered rs/rt addr and data):
  - MEM match: mem_reg_write & mem_write_addr!=0 & addr match → mem_result.
  - else WB match (same rule) → wb_result.
  - else registered register-file data.
  - MEM has priority over WB when both match.
  - Register 0 is never forwarded.
- Operand select:
  - alu_op_x = ex_shift_shamt ? {27'b0, shamt} : fwd_rs.
  - alu_op_y = ex_alu_src_imm ? imm : fwd_rt.
  - ex_store_data = fwd_rt, always forwarded.
- Latency: one cycle from ID capture to ALU operands. Forwarding is same-cycle with MEM/WB inputs.
- A load in EX that is flushed never causes a hazard, because its ex_valid=0.

Test Plan:
- Reset mid-operation: ex_valid=1 with opcode ADD, assert rst asynchronously between edges → ex_valid=0, alu_opcode=`ALU_ADDU, bubble_count=0 immediately.
- Plain capture: rs_data=5, rt_data=7, opcode ADD, no matches → next cycle alu_op_x=5, alu_op_y=7, ex_valid=1.
- MEM vs WB priority: EX rs=r3; mem writes r3=0x11, wb writes r3=0x22 → alu_op_x=0x11. With mem_reg_write=0 → alu_op_x=0x22.
- r0 guard: rs=r0, mem_write_addr=0, mem_reg_write=1, mem_result=0xDEAD → alu_op_x=0.
- Load-use: lw r4 in EX, ID add rs=r4 → stall_id=1 for one cycle, bubble in EX (ex_valid=0), bubble_count=1. The add enters EX next cycle, and WB forwarding supplies the loaded value.
- Flush+hazard together: same load-use setup with flush=1 → stall_id=0, bubble inserted, bubble_count unchanged. id_uses_rt=0 with rt match → no stall.
